// File: rtl/ysyx_22040365_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer:
// FSM state encodings, memory-op and instruction-class codes, small helpers.
package ysyx_22040365_ctrl_pkg;

    typedef enum logic [3:0] {
        CTRL_FETCH  = 4'd0,
        CTRL_FWAIT  = 4'd1,
        CTRL_DECODE = 4'd2,
        CTRL_EXEC   = 4'd3,
        CTRL_MREQ   = 4'd4,
        CTRL_MWAIT  = 4'd5,
        CTRL_WB     = 4'd6,
        CTRL_HALT   = 4'd7
    } ctrl_state_e;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    localparam logic [1:0] INST_INVALID = 2'b00;
    localparam logic [1:0] INST_INT     = 2'b01;
    localparam logic [1:0] INST_MEM     = 2'b10;
    localparam logic [1:0] INST_CTL     = 2'b11;

    // States in which the sequencer waits on an external handshake.
    function automatic logic is_wait_state(input ctrl_state_e s);
        return (s == CTRL_FETCH) || (s == CTRL_FWAIT) ||
               (s == CTRL_MREQ)  || (s == CTRL_MWAIT);
    endfunction

    // Reserved op 2'b11 is treated like no memory access.
    function automatic logic is_mem_access(input logic [1:0] op);
        return (op == MEM_LOAD) || (op == MEM_STORE);
    endfunction

endpackage

// File: rtl/ysyx_22040365_ctrl_if.sv
// Fetch and data-memory valid/ready handshake bundle between the sequencer
// (master) and the memory side (slave).
interface ysyx_22040365_ctrl_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [63:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;

    modport master (
        output ifu_req_valid, ifu_addr, lsu_req_valid,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, lsu_req_ready, lsu_rsp_valid
    );

    modport slave (
        input  ifu_req_valid, ifu_addr, lsu_req_valid,
        output ifu_req_ready, ifu_rsp_valid, ifu_rdata, lsu_req_ready, lsu_rsp_valid
    );
endinterface

// File: rtl/ysyx_22040365_ctrl_wdog.sv
// Wait-state watchdog: counter cleared on entry to a wait state, incremented
// while waiting, flagging the last permitted cycle.
module ysyx_22040365_ctrl_wdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired_o = (count_q == CW'(TIMEOUT - 1));

    // Saturate at the expiry value so a stalled owner never wraps the count.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !expired_o) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/ysyx_22040365_ctrl.sv
// Multi-cycle sequencer for the single-issue RV64 core: owns PC/IR, drives the
// fetch and data handshakes, gates writeback, counts retirements, halts on ebreak.
module ysyx_22040365_ctrl
    import ysyx_22040365_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_22040365_ctrl_if.master        bus,
    output logic [31:0]                 ir,
    input  logic [1:0]                  inst_type,
    input  logic [1:0]                  mem_op,
    input  logic                        is_ebreak,
    input  logic [63:0]                 next_pc,
    output logic                        ex_en,
    output logic                        rf_wen,
    output logic [63:0]                 pc,
    output logic [63:0]                 instret,
    output logic                        halt,
    output logic                        err,
    output logic [3:0]                  state
);
    ctrl_state_e state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [63:0] instret_q, instret_d;
    logic        halt_q, halt_d;
    logic        err_q, err_d;
    logic        wd_clear, wd_inc, wd_expired;

    ysyx_22040365_ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wd_clear),
        .inc_i     (wd_inc),
        .expired_o (wd_expired)
    );

    assign wd_clear = (state_d != state_q) && is_wait_state(state_d);
    assign wd_inc   = is_wait_state(state_q);

    // Outputs depend on registered state only (mem_op/ir are stable through WB).
    assign bus.ifu_req_valid = (state_q == CTRL_FETCH);
    assign bus.ifu_addr      = pc_q;
    assign bus.lsu_req_valid = (state_q == CTRL_MREQ);
    assign ex_en             = (state_q == CTRL_EXEC);
    assign rf_wen            = (state_q == CTRL_WB) && (mem_op != MEM_STORE);
    assign ir                = ir_q;
    assign pc                = pc_q;
    assign instret           = instret_q;
    assign halt              = halt_q;
    assign err               = err_q;
    assign state             = state_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        halt_d    = halt_q;
        err_d     = err_q;
        case (state_q)
            CTRL_FETCH: begin
                if (bus.ifu_req_ready) begin
                    state_d = CTRL_FWAIT;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = CTRL_HALT;
                end
            end
            CTRL_FWAIT: begin
                if (bus.ifu_rsp_valid) begin
                    ir_d    = bus.ifu_rdata;
                    state_d = CTRL_DECODE;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = CTRL_HALT;
                end
            end
            CTRL_DECODE: begin
                if (is_ebreak) begin
                    halt_d    = 1'b1;
                    instret_d = instret_q + 64'd1;
                    state_d   = CTRL_HALT;
                end else if (inst_type == INST_INVALID) begin
                    err_d   = 1'b1;
                    state_d = CTRL_HALT;
                end else begin
                    state_d = CTRL_EXEC;
                end
            end
            CTRL_EXEC: begin
                state_d = is_mem_access(mem_op) ? CTRL_MREQ : CTRL_WB;
            end
            CTRL_MREQ: begin
                if (bus.lsu_req_ready) begin
                    state_d = CTRL_MWAIT;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = CTRL_HALT;
                end
            end
            CTRL_MWAIT: begin
                if (bus.lsu_rsp_valid) begin
                    state_d = CTRL_WB;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = CTRL_HALT;
                end
            end
            CTRL_WB: begin
                pc_d      = next_pc;
                instret_d = instret_q + 64'd1;
                state_d   = CTRL_FETCH;
            end
            CTRL_HALT: begin
                state_d = CTRL_HALT;
            end
            default: begin
                state_d = CTRL_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CTRL_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            instret_q <= '0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            halt_q    <= halt_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22040365_ctrl.sv
// Randomised bench for the control sequencer: a cycle schedule is generated
// from instruction-level rules, then replayed and compared every cycle.
module tb_ysyx_22040365_ctrl;
    import ysyx_22040365_ctrl_pkg::*;

    localparam int unsigned TMO    = 8;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir;
    logic [1:0]  inst_type = '0;
    logic [1:0]  mem_op = '0;
    logic        is_ebreak = 1'b0;
    logic [63:0] next_pc = '0;
    logic        ex_en, rf_wen, halt, err;
    logic [63:0] pc, instret;
    logic [3:0]  state;

    ysyx_22040365_ctrl_if bus_if();

    ysyx_22040365_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .ir        (ir),
        .inst_type (inst_type),
        .mem_op    (mem_op),
        .is_ebreak (is_ebreak),
        .next_pc   (next_pc),
        .ex_en     (ex_en),
        .rf_wen    (rf_wen),
        .pc        (pc),
        .instret   (instret),
        .halt      (halt),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        ifu_req_ready;
        logic        ifu_rsp_valid;
        logic [31:0] ifu_rdata;
        logic        lsu_req_ready;
        logic        lsu_rsp_valid;
        logic [1:0]  inst_type;
        logic [1:0]  mem_op;
        logic        is_ebreak;
        logic [63:0] next_pc;
        logic        chk;
        logic [3:0]  e_state;
        logic [63:0] e_pc;
        logic [63:0] e_instret;
        logic [31:0] e_ir;
        logic        e_halt;
        logic        e_err;
        logic        e_rf_wen;
        logic        lit;
        logic [3:0]  l_state;
        logic [63:0] l_pc;
        logic [63:0] l_instret;
        logic        l_err;
    } cyc_t;

    cyc_t stim_q[$];
    cyc_t chk_q[$];

    // Architectural model of what the sequencer has committed so far.
    logic [63:0] m_pc = RST_PC;
    logic [63:0] m_instret = '0;
    logic [31:0] m_ir = '0;
    logic        m_halt = 1'b0;
    logic        m_err = 1'b0;
    logic [1:0]  d_type = '0;
    logic [1:0]  d_mem = '0;
    logic        d_ebk = 1'b0;
    logic [31:0] cur_rdata = '0;

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic emit(input ctrl_state_e st, input bit hs, input bit dec, input logic [63:0] npc);
        cyc_t c;
        c = '0;
        c.ifu_req_ready = 1'($urandom);
        c.ifu_rsp_valid = 1'($urandom);
        c.ifu_rdata     = $urandom;
        c.lsu_req_ready = 1'($urandom);
        c.lsu_rsp_valid = 1'($urandom);
        c.inst_type     = 2'($urandom);
        c.mem_op        = 2'($urandom);
        c.is_ebreak     = 1'($urandom);
        c.next_pc       = {$urandom, $urandom};
        case (st)
            CTRL_FETCH: c.ifu_req_ready = hs;
            CTRL_FWAIT: begin
                c.ifu_rsp_valid = hs;
                if (hs) c.ifu_rdata = cur_rdata;
            end
            CTRL_MREQ:  c.lsu_req_ready = hs;
            CTRL_MWAIT: c.lsu_rsp_valid = hs;
            default: ;
        endcase
        if (dec) begin
            c.inst_type = d_type;
            c.mem_op    = d_mem;
            c.is_ebreak = d_ebk;
        end
        if (st == CTRL_WB) c.next_pc = npc;
        c.chk       = 1'b1;
        c.e_state   = st;
        c.e_pc      = m_pc;
        c.e_instret = m_instret;
        c.e_ir      = m_ir;
        c.e_halt    = m_halt;
        c.e_err     = m_err;
        c.e_rf_wen  = (st == CTRL_WB) && (d_mem != MEM_STORE);
        stim_q.push_back(c);
    endtask

    // A wait phase lasts until the handshake cycle, or TMO cycles then errors.
    task automatic run_wait(input ctrl_state_e st, input int lat, input bit dec, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < int'(TMO); k++) begin
            if (k == lat) begin
                emit(st, 1'b1, dec, '0);
                ok = 1'b1;
                break;
            end
            emit(st, 1'b0, dec, '0);
        end
        if (!ok) m_err = 1'b1;
    endtask

    task automatic run_inst(input logic [31:0] idata, input logic [1:0] itype, input logic [1:0] mop,
                            input bit ebk, input int fl, input int rl, input int ql, input int sl,
                            input logic [63:0] npc, output bit halted);
        bit ok;
        halted    = 1'b1;
        cur_rdata = idata;
        run_wait(CTRL_FETCH, fl, 1'b0, ok);
        if (!ok) return;
        run_wait(CTRL_FWAIT, rl, 1'b0, ok);
        if (!ok) return;
        m_ir   = idata;
        d_type = itype;
        d_mem  = mop;
        d_ebk  = ebk;
        emit(CTRL_DECODE, 1'b0, 1'b1, '0);
        if (ebk) begin
            m_halt    = 1'b1;
            m_instret = m_instret + 64'd1;
            return;
        end
        if (itype == INST_INVALID) begin
            m_err = 1'b1;
            return;
        end
        emit(CTRL_EXEC, 1'b0, 1'b1, '0);
        if (mop == MEM_LOAD || mop == MEM_STORE) begin
            run_wait(CTRL_MREQ, ql, 1'b1, ok);
            if (!ok) return;
            run_wait(CTRL_MWAIT, sl, 1'b1, ok);
            if (!ok) return;
        end
        emit(CTRL_WB, 1'b0, 1'b1, npc);
        m_pc      = npc;
        m_instret = m_instret + 64'd1;
        halted    = 1'b0;
    endtask

    task automatic halt_tail(input int n);
        for (int k = 0; k < n; k++) emit(CTRL_HALT, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        cyc_t c;
        c = '0;
        c.rst           = 1'b1;
        c.ifu_req_ready = 1'($urandom);
        c.ifu_rsp_valid = 1'($urandom);
        c.lsu_req_ready = 1'($urandom);
        c.lsu_rsp_valid = 1'($urandom);
        stim_q.push_back(c);
        m_pc      = RST_PC;
        m_instret = '0;
        m_ir      = '0;
        m_halt    = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic pin(input int idx, input ctrl_state_e st, input logic [63:0] p,
                       input logic [63:0] n, input logic e);
        cyc_t c;
        c           = stim_q[idx];
        c.lit       = 1'b1;
        c.l_state   = st;
        c.l_pc      = p;
        c.l_instret = n;
        c.l_err     = e;
        stim_q[idx] = c;
    endtask

    function automatic int rlat();
        if ($urandom_range(0, 11) == 0) return int'($urandom_range(6, 9));
        return int'($urandom_range(0, 3));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp, input int cyc);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // Single compare process: one schedule entry per cycle, sampled at negedge.
    initial begin
        cyc_t e;
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (chk_q.size() > 0) begin
                e = chk_q.pop_front();
                cyc++;
                if (e.chk) begin
                    check("state",         64'(state),                64'(e.e_state),                    cyc);
                    check("ifu_req_valid", 64'(bus_if.ifu_req_valid), 64'(e.e_state == CTRL_FETCH),      cyc);
                    check("ifu_addr",      bus_if.ifu_addr,           e.e_pc,                            cyc);
                    check("lsu_req_valid", 64'(bus_if.lsu_req_valid), 64'(e.e_state == CTRL_MREQ),       cyc);
                    check("ex_en",         64'(ex_en),                64'(e.e_state == CTRL_EXEC),       cyc);
                    check("rf_wen",        64'(rf_wen),               64'(e.e_rf_wen),                   cyc);
                    check("pc",            pc,                        e.e_pc,                            cyc);
                    check("instret",       instret,                   e.e_instret,                       cyc);
                    check("ir",            64'(ir),                   64'(e.e_ir),                       cyc);
                    check("halt",          64'(halt),                 64'(e.e_halt),                     cyc);
                    check("err",           64'(err),                  64'(e.e_err),                      cyc);
                    if (e.e_state == CTRL_WB)
                        $display("retire pc=%h next_pc=%h instret=%0d rf_wen=%0d", pc, e.next_pc, instret, rf_wen);
                end
                if (e.lit) begin
                    check("lit_state",   64'(state), 64'(e.l_state), cyc);
                    check("lit_pc",      pc,         e.l_pc,         cyc);
                    check("lit_instret", instret,    e.l_instret,    cyc);
                    check("lit_err",     64'(err),   64'(e.l_err),   cyc);
                end
            end
        end
    end

    initial begin
        cyc_t c;
        bit   h;
        int   b;
        bus_if.ifu_req_ready = 1'b0;
        bus_if.ifu_rsp_valid = 1'b0;
        bus_if.ifu_rdata     = '0;
        bus_if.lsu_req_ready = 1'b0;
        bus_if.lsu_rsp_valid = 1'b0;

        do_reset();
        do_reset();
        // addi with zero-latency memory: FETCH, FWAIT, DECODE, EXEC, WB.
        b = stim_q.size();
        run_inst(32'h0010_0093, INST_INT, MEM_NONE, 1'b0, 0, 0, 0, 0, 64'h8000_0004, h);
        pin(b,     CTRL_FETCH, 64'h8000_0000, 64'd0, 1'b0);
        pin(b + 3, CTRL_EXEC,  64'h8000_0000, 64'd0, 1'b0);
        pin(b + 4, CTRL_WB,    64'h8000_0000, 64'd0, 1'b0);
        // ready low 3 cycles, response 2 cycles after accept
        b = stim_q.size();
        run_inst(32'h0020_8113, INST_INT, MEM_NONE, 1'b0, 3, 1, 0, 0, 64'h8000_0008, h);
        pin(b,     CTRL_FETCH,  64'h8000_0004, 64'd1, 1'b0);
        pin(b + 6, CTRL_DECODE, 64'h8000_0004, 64'd1, 1'b0);
        run_inst(32'h0000_b183, INST_MEM, MEM_LOAD,  1'b0, 0, 0, 2, 0, 64'h8000_000c, h);
        run_inst(32'h0030_b023, INST_MEM, MEM_STORE, 1'b0, 0, 0, 2, 1, 64'h8000_0010, h);
        // ebreak: pc held, instret bumped, quiet for 20 cycles
        b = stim_q.size();
        run_inst(32'h0010_0073, INST_CTL, MEM_NONE, 1'b1, 0, 0, 0, 0, '0, h);
        halt_tail(20);
        pin(b + 3,  CTRL_HALT, 64'h8000_0010, 64'd5, 1'b0);
        pin(b + 22, CTRL_HALT, 64'h8000_0010, 64'd5, 1'b0);
        do_reset();
        b = stim_q.size();
        run_inst(32'hffff_ffff, INST_INVALID, MEM_LOAD, 1'b0, 0, 0, 0, 0, '0, h);
        halt_tail(5);
        pin(b + 3, CTRL_HALT, 64'h8000_0000, 64'd0, 1'b1);
        do_reset();
        pin(stim_q.size() - 1, CTRL_HALT, 64'h8000_0000, 64'd0, 1'b1);
        // fetch never accepted: err 8 cycles after entering FETCH
        b = stim_q.size();
        run_inst(32'h0000_0013, INST_INT, MEM_NONE, 1'b0, 100, 0, 0, 0, '0, h);
        halt_tail(3);
        pin(b + 7, CTRL_FETCH, 64'h8000_0000, 64'd0, 1'b0);
        pin(b + 8, CTRL_HALT,  64'h8000_0000, 64'd0, 1'b1);
        do_reset();
        // ready arrives in the expiry cycle: handshake wins
        b = stim_q.size();
        run_inst(32'h0000_0013, INST_INT, MEM_NONE, 1'b0, 7, 0, 0, 0, 64'h8000_0004, h);
        pin(b + 8, CTRL_FWAIT, 64'h8000_0000, 64'd0, 1'b0);
        // reset while a fetch response is outstanding
        cur_rdata = 32'h1234_5678;
        run_wait(CTRL_FETCH, 0, 1'b0, h);
        emit(CTRL_FWAIT, 1'b0, 1'b0, '0);
        emit(CTRL_FWAIT, 1'b0, 1'b0, '0);
        do_reset();

        for (int n = 0; n < 150; n++) begin
            int          kind;
            logic [1:0]  t;
            logic [1:0]  m;
            bit          ek;
            kind = int'($urandom_range(0, 19));
            ek   = 1'b0;
            if (kind < 8 || kind > 17) begin
                t = 2'($urandom_range(1, 3));
                m = ($urandom_range(0, 3) == 0) ? 2'b11 : MEM_NONE;
            end else if (kind < 12) begin
                t = INST_MEM;
                m = MEM_LOAD;
            end else if (kind < 16) begin
                t = INST_MEM;
                m = MEM_STORE;
            end else if (kind == 16) begin
                t  = 2'($urandom);
                m  = 2'($urandom);
                ek = 1'b1;
            end else begin
                t = INST_INVALID;
                m = 2'($urandom);
            end
            run_inst($urandom, t, m, ek, rlat(), rlat(), rlat(), rlat(), {$urandom, $urandom}, h);
            if (h) begin
                halt_tail(int'($urandom_range(1, 4)));
                do_reset();
            end
        end

        @(posedge clk);
        #1;
        while (stim_q.size() > 0) begin
            c = stim_q.pop_front();
            rst                  = c.rst;
            bus_if.ifu_req_ready = c.ifu_req_ready;
            bus_if.ifu_rsp_valid = c.ifu_rsp_valid;
            bus_if.ifu_rdata     = c.ifu_rdata;
            bus_if.lsu_req_ready = c.lsu_req_ready;
            bus_if.lsu_rsp_valid = c.lsu_rsp_valid;
            inst_type            = c.inst_type;
            mem_op               = c.mem_op;
            is_ebreak            = c.is_ebreak;
            next_pc              = c.next_pc;
            chk_q.push_back(c);
            @(posedge clk);
            #1;
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
